// File: rtl/sha256_arb_pkg.sv
// sha256_arb_pkg: shared types and constants for the SHA-256 engine arbiter
package sha256_arb_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;
    localparam int HASH_W = 256;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] TERM_BYTE = 8'h00;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first request after last_owner
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      idx
);
    always_comb begin
        idx = '0;
        // scanned farthest-first so the nearest candidate after last_owner overwrites
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[IW'((int'(last_owner) + k) % NUM_REQ)])
                idx = IW'((int'(last_owner) + k) % NUM_REQ);
        pick = '0;
        if (|req)
            pick[idx] = 1'b1;
    end
endmodule

// File: rtl/sha256_engine_arbiter.sv
// sha256_engine_arbiter: round-robin sharing of one SHA-256 engine among byte-stream requesters
module sha256_engine_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    input  logic [8*NUM_REQ-1:0]  byte_data,
    input  logic [NUM_REQ-1:0]    byte_valid,
    input  logic [NUM_REQ-1:0]    byte_last,
    output logic [NUM_REQ-1:0]    res_valid,
    output logic                  res_err,
    output logic [HASH_W-1:0]     hash_out,
    output logic                  sha_start,
    output logic [BYTE_W-1:0]     sha_data,
    output logic                  sha_valid,
    output logic                  sha_last,
    input  logic [HASH_W-1:0]     sha_hash,
    input  logic                  sha_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TIMEOUT);
    localparam logic [CW-1:0] TERM_AT = CW'(IDLE_TIMEOUT - 1);

    state_t state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, res_valid_q, res_valid_d, pick;
    logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic err_q, err_d, res_err_q, res_err_d;
    logic start_q, start_d, valid_q, valid_d, slast_q, slast_d;
    logic [BYTE_W-1:0] data_q, data_d, own_data;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic own_valid, own_last;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(req), .last_owner(last_q), .pick(pick), .idx(pick_idx)
    );

    assign own_valid = byte_valid[owner_q];
    assign own_last  = byte_last[owner_q];
    assign own_data  = byte_data[{owner_q, 3'b000} +: BYTE_W];
    assign cnt_nxt   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = cnt_q;
        err_d = err_q;
        hash_d = hash_q;
        start_d = 1'b0;
        valid_d = 1'b0;
        data_d = '0;
        slast_d = 1'b0;
        res_valid_d = '0;
        res_err_d = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                gnt_d = pick;
                owner_d = pick_idx;
                start_d = 1'b1;
                cnt_d = '0;
                err_d = 1'b0;
                state_d = STREAM;
            end
            STREAM: if (own_valid) begin
                valid_d = 1'b1;
                data_d = own_data;
                slast_d = own_last;
                cnt_d = '0;
                state_d = own_last ? WAIT_DONE : STREAM;
            end else if (!req[owner_q] || cnt_nxt == TERM_AT) begin
                valid_d = 1'b1;
                slast_d = 1'b1;
                data_d = TERM_BYTE;
                err_d = 1'b1;
                state_d = WAIT_DONE;
            end else begin
                cnt_d = cnt_nxt;
            end
            WAIT_DONE: if (sha_done) begin
                hash_d = sha_hash;
                res_valid_d = gnt_q;
                res_err_d = err_q;
                gnt_d = '0;
                last_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            owner_q <= '0;
            last_q <= IW'(NUM_REQ - 1);
            cnt_q <= '0;
            err_q <= 1'b0;
            hash_q <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            data_q <= '0;
            slast_q <= 1'b0;
            res_valid_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            hash_q <= hash_d;
            start_q <= start_d;
            valid_q <= valid_d;
            data_q <= data_d;
            slast_q <= slast_d;
            res_valid_q <= res_valid_d;
            res_err_q <= res_err_d;
        end
    end

    assign gnt = gnt_q;
    assign res_valid = res_valid_q;
    assign res_err = res_err_q;
    assign hash_out = hash_q;
    assign sha_start = start_q;
    assign sha_data = data_q;
    assign sha_valid = valid_q;
    assign sha_last = slast_q;
endmodule

// File: tb/tb_sha256_engine_arbiter.sv
// tb_sha256_engine_arbiter: directed scenario bench for the SHA-256 engine arbiter
module tb_sha256_engine_arbiter;
    localparam logic [255:0] ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] JUNK = {8{32'hdeadbeef}};
    localparam logic [255:0] H0 = {8{32'h00c0ffee}};
    localparam logic [255:0] H1 = {8{32'h11111111}};
    localparam logic [255:0] H2 = {8{32'h22222222}};
    localparam logic [255:0] H3 = {8{32'h33333333}};
    localparam logic [255:0] H4 = {8{32'h44444444}};
    localparam logic [255:0] H5 = {8{32'h55555555}};

    logic clk = 1'b0, rst;
    logic [1:0] req, gnt, byte_valid, byte_last, res_valid;
    logic [15:0] byte_data;
    logic res_err, sha_start, sha_valid, sha_last, sha_done;
    logic [7:0] sha_data;
    logic [255:0] hash_out, sha_hash;
    int total = 0, bad = 0;

    sha256_engine_arbiter #(.NUM_REQ(2), .IDLE_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
        .res_valid(res_valid), .res_err(res_err), .hash_out(hash_out),
        .sha_start(sha_start), .sha_data(sha_data), .sha_valid(sha_valid), .sha_last(sha_last),
        .sha_hash(sha_hash), .sha_done(sha_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int i, input logic [7:0] d, input logic v, input logic l);
        byte_data[i*8 +: 8] = d;
        byte_valid[i] = v;
        byte_last[i] = l;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; byte_data = '0; byte_valid = '0; byte_last = '0;
        sha_done = 1'b0; sha_hash = '0;
        tick; tick;
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        total++; if ({sha_start, sha_valid, sha_last, sha_data} !== 11'd0) begin bad++; $display("FAIL reset_sha got=%b%b%b %h exp=0", sha_start, sha_valid, sha_last, sha_data); end
        total++; if ({res_valid, res_err} !== 3'd0) begin bad++; $display("FAIL reset_res got=%b %b exp=0", res_valid, res_err); end
        total++; if (hash_out !== '0) begin bad++; $display("FAIL reset_hash got=%h exp=0", hash_out); end
        rst = 1'b0;
    endtask

    task automatic test_abc;
        req = 2'b01;
        tick;
        total++; if (gnt !== 2'b01 || sha_start !== 1'b1) begin bad++; $display("FAIL abc_grant got=%b start=%b exp=01 start=1", gnt, sha_start); end
        lane(0, 8'h61, 1'b1, 1'b0);
        tick;
        total++; if ({sha_start, sha_valid, sha_last, sha_data} !== {3'b010, 8'h61}) begin bad++; $display("FAIL abc_b0 got=%b%b%b %h exp=010 61", sha_start, sha_valid, sha_last, sha_data); end
        lane(0, 8'h62, 1'b1, 1'b0);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b10, 8'h62}) begin bad++; $display("FAIL abc_b1 got=%b%b %h exp=10 62", sha_valid, sha_last, sha_data); end
        lane(0, 8'h63, 1'b1, 1'b1);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h63}) begin bad++; $display("FAIL abc_b2 got=%b%b %h exp=11 63", sha_valid, sha_last, sha_data); end
        lane(0, 8'h00, 1'b0, 1'b0);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== 10'd0) begin bad++; $display("FAIL abc_wait got=%b%b %h exp=0", sha_valid, sha_last, sha_data); end
        sha_done = 1'b1; sha_hash = ABC;
        tick;
        total++; if (res_valid !== 2'b01 || res_err !== 1'b0 || gnt !== 2'b00) begin bad++; $display("FAIL abc_res got=%b err=%b gnt=%b exp=01 0 00", res_valid, res_err, gnt); end
        total++; if (hash_out !== ABC) begin bad++; $display("FAIL abc_hash got=%h exp=%h", hash_out, ABC); end
        sha_done = 1'b0; req = 2'b00;
        tick;
        total++; if (res_valid !== 2'b00 || res_err !== 1'b0 || hash_out !== ABC) begin bad++; $display("FAIL abc_after got=%b err=%b hash=%h", res_valid, res_err, hash_out); end
    endtask

    task automatic test_spurious_done;
        sha_done = 1'b1; sha_hash = JUNK;
        tick;
        total++; if (res_valid !== 2'b00 || hash_out !== ABC) begin bad++; $display("FAIL spur_idle got=%b hash=%h exp=00 %h", res_valid, hash_out, ABC); end
        sha_done = 1'b0; req = 2'b01;
        tick;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL spur_gnt got=%b exp=01", gnt); end
        sha_done = 1'b1;
        tick;
        total++; if (res_valid !== 2'b00 || hash_out !== ABC || sha_valid !== 1'b0) begin bad++; $display("FAIL spur_stream got=%b hash=%h valid=%b", res_valid, hash_out, sha_valid); end
        sha_done = 1'b0; req = 2'b00;
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h00}) begin bad++; $display("FAIL spur_term got=%b%b %h exp=11 00", sha_valid, sha_last, sha_data); end
        sha_done = 1'b1; sha_hash = H0;
        tick;
        total++; if (res_valid !== 2'b01 || res_err !== 1'b1 || hash_out !== H0) begin bad++; $display("FAIL spur_res got=%b err=%b hash=%h", res_valid, res_err, hash_out); end
        sha_done = 1'b0;
        tick;
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        tick;
        rst = 1'b0; req = 2'b11;
        tick;
        total++; if (gnt !== 2'b01 || sha_start !== 1'b1) begin bad++; $display("FAIL rr_first got=%b start=%b exp=01 1", gnt, sha_start); end
        lane(1, 8'hAA, 1'b1, 1'b0);
        tick;
        total++; if (sha_valid !== 1'b0 || sha_start !== 1'b0) begin bad++; $display("FAIL rr_ignore got=valid %b start %b exp=0 0", sha_valid, sha_start); end
        lane(0, 8'h11, 1'b1, 1'b1); lane(1, 8'hBB, 1'b1, 1'b1);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h11}) begin bad++; $display("FAIL rr_b0 got=%b%b %h exp=11 11", sha_valid, sha_last, sha_data); end
        lane(0, 8'h00, 1'b0, 1'b0); lane(1, 8'h00, 1'b0, 1'b0);
        sha_done = 1'b1; sha_hash = H1;
        tick;
        total++; if (res_valid !== 2'b01 || gnt !== 2'b00 || hash_out !== H1) begin bad++; $display("FAIL rr_res0 got=%b gnt=%b hash=%h", res_valid, gnt, hash_out); end
        sha_done = 1'b0;
        tick;
        total++; if (gnt !== 2'b10 || sha_start !== 1'b1) begin bad++; $display("FAIL rr_second got=%b start=%b exp=10 1", gnt, sha_start); end
        lane(1, 8'h22, 1'b1, 1'b1);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h22}) begin bad++; $display("FAIL rr_b1 got=%b%b %h exp=11 22", sha_valid, sha_last, sha_data); end
        lane(1, 8'h00, 1'b0, 1'b0);
        sha_done = 1'b1; sha_hash = H2;
        tick;
        total++; if (res_valid !== 2'b10 || res_err !== 1'b0 || hash_out !== H2) begin bad++; $display("FAIL rr_res1 got=%b err=%b hash=%h", res_valid, res_err, hash_out); end
        sha_done = 1'b0;
        tick;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_third got=%b exp=01", gnt); end
    endtask

    task automatic test_req_drop;
        req = 2'b10;
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h00}) begin bad++; $display("FAIL drop_term got=%b%b %h exp=11 00", sha_valid, sha_last, sha_data); end
        sha_done = 1'b1; sha_hash = H3;
        tick;
        total++; if (res_valid !== 2'b01 || res_err !== 1'b1 || hash_out !== H3) begin bad++; $display("FAIL drop_res got=%b err=%b hash=%h", res_valid, res_err, hash_out); end
        sha_done = 1'b0;
        tick;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL drop_next_gnt got=%b exp=10", gnt); end
        lane(1, 8'h33, 1'b1, 1'b1);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h33}) begin bad++; $display("FAIL drop_b1 got=%b%b %h exp=11 33", sha_valid, sha_last, sha_data); end
        lane(1, 8'h00, 1'b0, 1'b0);
        sha_done = 1'b1; sha_hash = H4;
        tick;
        total++; if (res_valid !== 2'b10 || res_err !== 1'b0) begin bad++; $display("FAIL drop_res1 got=%b err=%b exp=10 0", res_valid, res_err); end
        sha_done = 1'b0; req = 2'b00;
        tick;
    endtask

    task automatic test_timeout;
        int fires;
        req = 2'b01;
        tick;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_gnt got=%b exp=01", gnt); end
        lane(0, 8'h5A, 1'b1, 1'b0);
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b10, 8'h5A}) begin bad++; $display("FAIL to_byte got=%b%b %h exp=10 5a", sha_valid, sha_last, sha_data); end
        lane(0, 8'h00, 1'b0, 1'b0);
        fires = 0;
        repeat (14) begin
            tick;
            if (sha_valid) fires++;
        end
        total++; if (fires !== 0) begin bad++; $display("FAIL to_early got=%0d exp=0", fires); end
        tick;
        total++; if ({sha_valid, sha_last, sha_data} !== {2'b11, 8'h00}) begin bad++; $display("FAIL to_term got=%b%b %h exp=11 00", sha_valid, sha_last, sha_data); end
        sha_done = 1'b1; sha_hash = H5;
        tick;
        total++; if (res_valid !== 2'b01 || res_err !== 1'b1 || hash_out !== H5) begin bad++; $display("FAIL to_res got=%b err=%b hash=%h", res_valid, res_err, hash_out); end
        sha_done = 1'b0; req = 2'b00;
        tick;
    endtask

    task automatic test_async_reset;
        req = 2'b01;
        tick;
        lane(0, 8'h77, 1'b1, 1'b0);
        tick;
        total++; if (sha_valid !== 1'b1 || gnt !== 2'b01) begin bad++; $display("FAIL ar_pre got=valid %b gnt %b exp=1 01", sha_valid, gnt); end
        #2 rst = 1'b1;
        #1;
        total++; if ({gnt, sha_valid, sha_data, sha_start, sha_last, res_valid, res_err} !== 16'd0) begin bad++; $display("FAIL ar_clear got=gnt %b valid %b data %h", gnt, sha_valid, sha_data); end
        total++; if (hash_out !== '0) begin bad++; $display("FAIL ar_hash got=%h exp=0", hash_out); end
        lane(0, 8'h00, 1'b0, 1'b0); req = 2'b00;
        tick;
        rst = 1'b0; req = 2'b10;
        tick;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL ar_gnt1 got=%b exp=10", gnt); end
        req = 2'b00;
        tick;
        sha_done = 1'b1;
        tick;
        total++; if (res_valid !== 2'b10 || res_err !== 1'b1) begin bad++; $display("FAIL ar_res got=%b err=%b exp=10 1", res_valid, res_err); end
        sha_done = 1'b0; req = 2'b11;
        tick;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL ar_gnt0 got=%b exp=01", gnt); end
        rst = 1'b1; req = 2'b00;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_abc;
        test_spurious_done;
        test_round_robin;
        test_req_drop;
        test_timeout;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
